// File: rtl/space_invaders_pkg.sv
// space_invaders_pkg
//   Shared types and screen constants for the game blocks.
//   bc_state_t : bullet controller life-cycle states.
//   H_ACTIVE / V_ACTIVE : visible raster size.
//   PLAYER_TOP_Y_DEFAULT : top row of the player sprite.
//   COORD_W : width of every screen coordinate bus.
package space_invaders_pkg;

    typedef enum logic [1:0] {
        BC_IDLE     = 2'd0,
        BC_FLYING   = 2'd1,
        BC_COOLDOWN = 2'd2
    } bc_state_t;

    localparam int H_ACTIVE             = 640;
    localparam int V_ACTIVE             = 480;
    localparam int PLAYER_TOP_Y_DEFAULT = 440;
    localparam int COORD_W              = 10;

endpackage

// File: rtl/frame_tick_sync.sv
// frame_tick_sync
//   Brings the slow VGA vsync into the system clock domain and turns each
//   rising edge into a single-cycle tick. Shared by every per-frame motion block.
// Ports
//   clk      in  1  system clock
//   rst      in  1  asynchronous, active-high reset
//   async_in in  1  asynchronous frame strobe (vsync)
//   tick     out 1  one-cycle pulse per rising edge of async_in
module frame_tick_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic tick
);

    logic sync_0;
    logic sync_1;
    logic sync_1_d;

    // NOTE: flops take non-blocking assignments so every register samples
    // the pre-edge value of its neighbour; blocking here would collapse the
    // synchroniser chain into a single stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_0   <= 1'b0;
            sync_1   <= 1'b0;
            sync_1_d <= 1'b0;
        end else begin
            sync_0   <= async_in;
            sync_1   <= sync_0;
            sync_1_d <= sync_1;
        end
    end

    assign tick = sync_1 & ~sync_1_d;

endmodule

// File: rtl/bullet_controller.sv
// bullet_controller
//   Owns the single player bullet: launches it from the player column on a
//   fire press, climbs it once per frame, retires it at the top edge or on a
//   hit, then holds off re-arming for a fixed number of frames.
// Ports
//   Clk        in  1   system clock
//   Reset      in  1   asynchronous, active-high reset
//   frame_clk  in  1   vsync; each rising edge is one frame tick
//   fire       in  1   fire key level
//   hit        in  1   one-cycle collision pulse
//   playerX    in  10  player centre column
//   bullet_in  out 1   bullet alive / visible
//   bulletX    out 10  bullet column (held while not alive)
//   bulletY    out 10  bullet top row (held while not alive)
//   shot_pulse out 1   one-cycle pulse on launch
//   busy       out 1   bullet flying or cooling down
module bullet_controller
    import space_invaders_pkg::*;
#(
    parameter int unsigned BULLET_SPEED = 4,
    parameter int unsigned BULLET_LEN   = 4,
    parameter int unsigned PLAYER_TOP_Y = PLAYER_TOP_Y_DEFAULT,
    parameter int unsigned X_MAX        = H_ACTIVE - 1,
    parameter int unsigned COOLDOWN_FR  = 8
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               frame_clk,
    input  logic               fire,
    input  logic               hit,
    input  logic [COORD_W-1:0] playerX,
    output logic               bullet_in,
    output logic [COORD_W-1:0] bulletX,
    output logic [COORD_W-1:0] bulletY,
    output logic               shot_pulse,
    output logic               busy
);

    localparam int CNT_W = $clog2(COOLDOWN_FR + 1);

    localparam logic [COORD_W-1:0] SPEED_V  = COORD_W'(BULLET_SPEED);
    localparam logic [COORD_W-1:0] LAUNCH_Y = COORD_W'(PLAYER_TOP_Y - BULLET_LEN);
    localparam logic [COORD_W-1:0] X_MAX_V  = COORD_W'(X_MAX);
    localparam logic [CNT_W-1:0]   CNT_INIT = CNT_W'(COOLDOWN_FR);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);

    bc_state_t          state, state_nxt;
    logic               fire_prev;
    logic               fire_pend, fire_pend_nxt;
    logic [CNT_W-1:0]   cd_cnt, cd_cnt_nxt;
    logic               bullet_in_nxt;
    logic [COORD_W-1:0] bulletX_nxt, bulletY_nxt;
    logic               shot_pulse_nxt;
    logic               tick;
    logic               fire_rise;

    frame_tick_sync u_frame_tick_sync (
        .clk      (Clk),
        .rst      (Reset),
        .async_in (frame_clk),
        .tick     (tick)
    );

    assign fire_rise = fire & ~fire_prev;
    assign busy      = (state != BC_IDLE);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state      <= BC_IDLE;
            fire_prev  <= 1'b0;
            fire_pend  <= 1'b0;
            cd_cnt     <= '0;
            bullet_in  <= 1'b0;
            bulletX    <= '0;
            bulletY    <= '0;
            shot_pulse <= 1'b0;
        end else begin
            state      <= state_nxt;
            fire_prev  <= fire;
            fire_pend  <= fire_pend_nxt;
            cd_cnt     <= cd_cnt_nxt;
            bullet_in  <= bullet_in_nxt;
            bulletX    <= bulletX_nxt;
            bulletY    <= bulletY_nxt;
            shot_pulse <= shot_pulse_nxt;
        end
    end

    always_comb begin
        // NOTE: every signal gets a hold/default value before the case so no
        // path leaves it unassigned, which would otherwise infer a latch.
        state_nxt      = state;
        fire_pend_nxt  = fire_pend;
        cd_cnt_nxt     = cd_cnt;
        bullet_in_nxt  = bullet_in;
        bulletX_nxt    = bulletX;
        bulletY_nxt    = bulletY;
        shot_pulse_nxt = 1'b0;

        case (state)
            BC_IDLE: begin
                if (tick && fire_pend) begin
                    // Pending press is consumed; a fresh edge this cycle is dropped.
                    state_nxt      = BC_FLYING;
                    bulletX_nxt    = (playerX > X_MAX_V) ? X_MAX_V : playerX;
                    bulletY_nxt    = LAUNCH_Y;
                    bullet_in_nxt  = 1'b1;
                    shot_pulse_nxt = 1'b1;
                    fire_pend_nxt  = 1'b0;
                end else if (fire_rise) begin
                    fire_pend_nxt = 1'b1;
                end
            end

            BC_FLYING: begin
                // Hit has priority over a coincident frame tick.
                if (hit) begin
                    state_nxt     = BC_COOLDOWN;
                    bullet_in_nxt = 1'b0;
                    cd_cnt_nxt    = CNT_INIT;
                end else if (tick) begin
                    // Compare before subtracting so the row never wraps.
                    if (bulletY < SPEED_V) begin
                        state_nxt     = BC_COOLDOWN;
                        bullet_in_nxt = 1'b0;
                        cd_cnt_nxt    = CNT_INIT;
                    end else begin
                        bulletY_nxt = bulletY - SPEED_V;
                    end
                end
            end

            BC_COOLDOWN: begin
                if (fire_rise) begin
                    fire_pend_nxt = 1'b1;
                end
                if (tick) begin
                    cd_cnt_nxt = (cd_cnt == '0) ? '0 : cd_cnt - CNT_ONE;
                    if (cd_cnt <= CNT_ONE) begin
                        state_nxt = BC_IDLE;
                    end
                end
            end

            default: begin
                state_nxt = BC_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bullet_controller.sv
// tb_bullet_controller
//   Self-checking bench for bullet_controller. A frame-level model tracks
//   whether a bullet is alive, its position, frames of cooldown left and a
//   pending press; every frame tick the DUT outputs are compared against it.
module tb_bullet_controller;

    localparam int SPEED = 4;
    localparam int LEN   = 4;
    localparam int TOP   = 440;
    localparam int XMAX  = 639;
    localparam int CD    = 8;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       frame_clk = 1'b0;
    logic       fire = 1'b0;
    logic       hit = 1'b0;
    logic [9:0] playerX = '0;
    logic       bullet_in;
    logic [9:0] bulletX;
    logic [9:0] bulletY;
    logic       shot_pulse;
    logic       busy;

    int checks   = 0;
    int failures = 0;
    int shot_cnt = 0;

    // Reference model state
    bit m_alive;
    bit m_pend;
    int m_x;
    int m_y;
    int m_cd;
    int m_px;
    int m_launches;

    bullet_controller dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_clk  (frame_clk),
        .fire       (fire),
        .hit        (hit),
        .playerX    (playerX),
        .bullet_in  (bullet_in),
        .bulletX    (bulletX),
        .bulletY    (bulletY),
        .shot_pulse (shot_pulse),
        .busy       (busy)
    );

    always #10 Clk = ~Clk;

    always @(posedge Clk) begin
        if (shot_pulse) shot_cnt++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    // ---------------- model ----------------
    function automatic void model_reset();
        m_alive = 1'b0;
        m_pend  = 1'b0;
        m_x     = 0;
        m_y     = 0;
        m_cd    = 0;
    endfunction

    function automatic bit model_tick(input bit hit_now, input bit edge_now);
        bit pre_alive;
        bit launched;
        pre_alive = m_alive;
        launched  = 1'b0;
        if (m_alive) begin
            if (hit_now || m_y < SPEED) begin
                m_alive = 1'b0;
                m_cd    = CD;
            end else begin
                m_y = m_y - SPEED;
            end
        end else if (m_cd > 0) begin
            m_cd = m_cd - 1;
        end else if (m_pend) begin
            m_alive = 1'b1;
            m_x     = (m_px > XMAX) ? XMAX : m_px;
            m_y     = TOP - LEN;
            m_pend  = 1'b0;
            launched = 1'b1;
            m_launches++;
        end
        if (edge_now && !pre_alive && !launched) m_pend = 1'b1;
        return launched;
    endfunction

    function automatic void model_hit();
        if (m_alive) begin
            m_alive = 1'b0;
            m_cd    = CD;
        end
    endfunction

    function automatic void model_edge();
        if (!m_alive) m_pend = 1'b1;
    endfunction

    function automatic logic [22:0] model_vec(input bit shot);
        return {m_alive, (m_alive || m_cd > 0), shot, 10'(m_x), 10'(m_y)};
    endfunction

    // ---------------- stimulus primitives ----------------
    task automatic set_px(input int v);
        playerX = 10'(v);
        m_px    = v;
    endtask

    // One vsync pulse; hit / a fresh fire edge can be placed in the tick cycle.
    task automatic frame(input string tag, input bit do_hit, input bit fire_edge);
        bit          launched;
        logic [22:0] exp;
        logic [22:0] got;
        frame_clk = 1'b1;
        @(posedge Clk);
        @(posedge Clk);
        @(negedge Clk);
        if (do_hit)    hit  = 1'b1;
        if (fire_edge) fire = 1'b1;
        @(posedge Clk);
        #1;
        hit = 1'b0;
        launched = model_tick(do_hit, fire_edge);
        exp = model_vec(launched);
        got = {bullet_in, busy, shot_pulse, bulletX, bulletY};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got in=%0b busy=%0b shot=%0b x=%0d y=%0d exp in=%0b busy=%0b shot=%0b x=%0d y=%0d",
                     tag, got[22], got[21], got[20], got[19:10], got[9:0],
                     exp[22], exp[21], exp[20], exp[19:10], exp[9:0]);
        end
        frame_clk = 1'b0;
        @(posedge Clk);
        #1;
        checks++;
        if (shot_pulse !== 1'b0) begin
            failures++;
            $display("FAIL %s_shot_width got=%0b exp=0", tag, shot_pulse);
        end
        @(posedge Clk);
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic press();
        @(negedge Clk);
        fire = 1'b1;
        @(posedge Clk);
        #1;
        model_edge();
        @(negedge Clk);
        fire = 1'b0;
        @(negedge Clk);
    endtask

    task automatic press_hold();
        @(negedge Clk);
        fire = 1'b1;
        @(posedge Clk);
        #1;
        model_edge();
        @(negedge Clk);
    endtask

    task automatic release_fire();
        @(negedge Clk);
        fire = 1'b0;
        @(negedge Clk);
    endtask

    task automatic hit_pulse(input string tag);
        @(negedge Clk);
        hit = 1'b1;
        @(posedge Clk);
        #1;
        hit = 1'b0;
        model_hit();
        checks++;
        if ({bullet_in, busy, bulletY} !== {m_alive, (m_alive || m_cd > 0), 10'(m_y)}) begin
            failures++;
            $display("FAIL %s got in=%0b busy=%0b y=%0d exp in=%0b busy=%0b y=%0d",
                     tag, bullet_in, busy, bulletY, m_alive, (m_alive || m_cd > 0), m_y);
        end
        @(negedge Clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        checks++;
        if ({bullet_in, busy, shot_pulse, bulletX, bulletY} !== 23'd0) begin
            failures++;
            $display("FAIL reset_state got in=%0b busy=%0b shot=%0b x=%0d y=%0d exp all zero",
                     bullet_in, busy, shot_pulse, bulletX, bulletY);
        end
        @(negedge Clk);
        Reset = 1'b0;
        model_reset();
        set_px(100);
        press();
        frame("rst_launch", 1'b0, 1'b0);
        repeat (59) frame("rst_climb", 1'b0, 1'b0);
        checks++;
        if (bulletY !== 10'd200) begin
            failures++;
            $display("FAIL rst_pre_y got=%0d exp=200", bulletY);
        end
        @(posedge Clk);
        #3;
        Reset = 1'b1;
        #1;
        checks++;
        if ({bullet_in, busy, shot_pulse, bulletX, bulletY} !== 23'd0) begin
            failures++;
            $display("FAIL reset_async got in=%0b busy=%0b shot=%0b x=%0d y=%0d exp all zero",
                     bullet_in, busy, shot_pulse, bulletX, bulletY);
        end
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        model_reset();
        frame("rst_after", 1'b0, 1'b0);
    endtask

    task automatic test_launch_climb();
        set_px(320);
        press();
        frame("launch", 1'b0, 1'b0);
        checks++;
        if ({bullet_in, bulletX, bulletY} !== {1'b1, 10'd320, 10'd436}) begin
            failures++;
            $display("FAIL launch_pos got in=%0b x=%0d y=%0d exp in=1 x=320 y=436",
                     bullet_in, bulletX, bulletY);
        end
        for (int k = 1; k <= 3; k++) begin
            frame("climb", 1'b0, 1'b0);
            checks++;
            if (bulletY !== 10'(436 - 4 * k)) begin
                failures++;
                $display("FAIL climb_y got=%0d exp=%0d", bulletY, 436 - 4 * k);
            end
        end
        hit_pulse("climb_hit");
        repeat (8) frame("climb_cd", 1'b0, 1'b0);
    endtask

    task automatic test_top_edge();
        press();
        frame("top_launch", 1'b0, 1'b0);
        repeat (109) frame("top_climb", 1'b0, 1'b0);
        checks++;
        if ({bullet_in, bulletY} !== {1'b1, 10'd0}) begin
            failures++;
            $display("FAIL top_at_zero got in=%0b y=%0d exp in=1 y=0", bullet_in, bulletY);
        end
        frame("top_retire", 1'b0, 1'b0);
        checks++;
        if ({bullet_in, busy, bulletY} !== {1'b0, 1'b1, 10'd0}) begin
            failures++;
            $display("FAIL top_retire got in=%0b busy=%0b y=%0d exp in=0 busy=1 y=0",
                     bullet_in, busy, bulletY);
        end
        repeat (7) frame("top_cd", 1'b0, 1'b0);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL top_cd7_busy got=%0b exp=1", busy);
        end
        frame("top_cd8", 1'b0, 1'b0);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL top_idle_busy got=%0b exp=0", busy);
        end
    endtask

    task automatic test_hit();
        set_px(50);
        press();
        frame("hit_launch", 1'b0, 1'b0);
        repeat (34) frame("hit_climb", 1'b0, 1'b0);
        frame("hit_tick", 1'b1, 1'b0);
        checks++;
        if ({bullet_in, busy, bulletY} !== {1'b0, 1'b1, 10'd300}) begin
            failures++;
            $display("FAIL hit_with_tick got in=%0b busy=%0b y=%0d exp in=0 busy=1 y=300",
                     bullet_in, busy, bulletY);
        end
        repeat (8) frame("hit_cd", 1'b0, 1'b0);
    endtask

    task automatic test_fire_hold();
        int s0;
        s0 = shot_cnt;
        press_hold();
        for (int k = 0; k < 40; k++) frame("hold", (k == 3), 1'b0);
        release_fire();
        checks++;
        if (shot_cnt - s0 !== 1) begin
            failures++;
            $display("FAIL hold_shots got=%0d exp=1", shot_cnt - s0);
        end
        press();
        frame("cdpress_launch", 1'b0, 1'b0);
        hit_pulse("cdpress_hit");
        press();
        repeat (8) frame("cdpress_cd", 1'b0, 1'b0);
        checks++;
        if ({bullet_in, busy} !== 2'b00) begin
            failures++;
            $display("FAIL cdpress_idle got in=%0b busy=%0b exp in=0 busy=0", bullet_in, busy);
        end
        frame("cdpress_fire", 1'b0, 1'b0);
        checks++;
        if (bullet_in !== 1'b1) begin
            failures++;
            $display("FAIL cdpress_relaunch got=%0b exp=1", bullet_in);
        end
        hit_pulse("cdpress_end");
        repeat (8) frame("cdpress_cd2", 1'b0, 1'b0);
    endtask

    task automatic test_clamp_flying_press();
        set_px(700);
        press();
        frame("clamp_launch", 1'b0, 1'b0);
        checks++;
        if (bulletX !== 10'd639) begin
            failures++;
            $display("FAIL clamp_x got=%0d exp=639", bulletX);
        end
        press();
        frame("fly_press", 1'b0, 1'b0);
        hit_pulse("fly_hit");
        repeat (9) frame("fly_after", 1'b0, 1'b0);
        checks++;
        if ({bullet_in, busy} !== 2'b00) begin
            failures++;
            $display("FAIL fly_press_ignored got in=%0b busy=%0b exp in=0 busy=0", bullet_in, busy);
        end
    endtask

    task automatic test_coincident();
        set_px(10);
        press();
        frame("coin_launch", 1'b0, 1'b1);
        release_fire();
        hit_pulse("coin_hit");
        repeat (9) frame("coin_after", 1'b0, 1'b0);
        checks++;
        if (bullet_in !== 1'b0) begin
            failures++;
            $display("FAIL coin_edge_dropped got=%0b exp=0", bullet_in);
        end
    endtask

    task automatic test_random();
        int s0;
        int l0;
        int r;
        s0 = shot_cnt;
        l0 = m_launches;
        for (int i = 0; i < 200; i++) begin
            r = $urandom_range(0, 9);
            case (r)
                5:       press();
                6:       hit_pulse("rnd_hit");
                7:       frame("rnd_tick_hit", 1'b1, 1'b0);
                8: begin
                    frame("rnd_tick_fire", 1'b0, 1'b1);
                    release_fire();
                end
                9:       set_px($urandom_range(0, 1023));
                default: frame("rnd_tick", 1'b0, 1'b0);
            endcase
        end
        checks++;
        if (shot_cnt - s0 !== m_launches - l0) begin
            failures++;
            $display("FAIL rnd_shot_count got=%0d exp=%0d", shot_cnt - s0, m_launches - l0);
        end
    endtask

    initial begin
        m_launches = 0;
        model_reset();
        m_px = 0;
        repeat (3) @(negedge Clk);
        test_reset();
        test_launch_climb();
        test_top_edge();
        test_hit();
        test_fire_hold();
        test_clamp_flying_press();
        test_coincident();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
